// File: rtl/imem_encoder_loader_if.sv
// Field-bundle stream in, instruction-memory write port out.
interface imem_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] imm;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  // Producer of instruction bundles / consumer of memory writes.
  modport master (
    output in_valid, in_last, fmt, opcode, rd, rs1, rs2, funct3, funct7b5, imm,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // The encoder/loader itself.
  modport slave (
    input  in_valid, in_last, fmt, opcode, rd, rs1, rs2, funct3, funct7b5, imm,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_encoder_loader.sv
// Packs RV32I instruction fields into machine words and writes them sequentially
// into instruction memory starting at BASE_ADDR.
module imem_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  imem_encoder_loader_if.slave     bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  localparam logic [2:0] FmtR = 3'd0;
  localparam logic [2:0] FmtI = 3'd1;
  localparam logic [2:0] FmtS = 3'd2;
  localparam logic [2:0] FmtB = 3'd3;
  localparam logic [2:0] FmtU = 3'd4;
  localparam logic [2:0] FmtJ = 3'd5;

  typedef enum logic [1:0] {StLoad, StFull, StHalt} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic [31:0]       word;
  logic              bad;
  logic              accept;

  // Field packing per instruction format; flags illegal formats and odd branch offsets.
  always_comb begin
    word = '0;
    bad  = 1'b0;
    case (bus.fmt)
      FmtR: word = {1'b0, bus.funct7b5, 5'b0, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      FmtI: begin
        // Immediate shifts carry funct7 in the upper immediate bits.
        if (bus.opcode == 7'h13 && (bus.funct3 == 3'b001 || bus.funct3 == 3'b101)) begin
          word = {1'b0, bus.funct7b5, 5'b0, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd,
                  bus.opcode};
        end else begin
          word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        end
      end
      FmtS: word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
      FmtB: begin
        word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:1],
                bus.imm[11], bus.opcode};
        bad  = bus.imm[0];
      end
      FmtU: word = {bus.imm[31:12], bus.rd, bus.opcode};
      FmtJ: begin
        word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.opcode};
        bad  = bus.imm[0];
      end
      default: bad = 1'b1;
    endcase
  end

  // Handshake, FSM next state and registered write-port next values.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    err_d       = err_q;
    done_d      = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    bus.in_ready = (state_q == StLoad) && !clear;
    accept       = bus.in_valid && bus.in_ready;

    if (clear) begin
      state_d    = StLoad;
      count_d    = '0;
      err_d      = 1'b0;
      mem_addr_d = BASE_ADDR;
    end else if (accept) begin
      if (bad) begin
        // Bundle is consumed but never written.
        err_d   = 1'b1;
        state_d = StHalt;
      end else begin
        mem_we_d    = 1'b1;
        mem_addr_d  = BASE_ADDR + (32'(count_q) << 2);
        mem_wdata_d = word;
        count_d     = count_q + CntW'(1);
        done_d      = bus.in_last;
        if (bus.in_last || count_d == CntW'(DEPTH)) begin
          state_d = StFull;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StLoad;
      count_q     <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      err_q       <= err_d;
      done_q      <= done_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign count         = count_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_imem_encoder_loader.sv
// Bench for imem_encoder_loader: directed table, corner sequences and random traffic
// checked against a behavioural model of the loader.
module tb_imem_encoder_loader;

  localparam logic [31:0] Base  = 32'h0000_0000;
  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [2:0] count;
  logic       done;
  logic       err;

  imem_encoder_loader_if bus ();

  imem_encoder_loader #(
    .BASE_ADDR (Base),
    .DEPTH     (Depth)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus),
    .count (count),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic        last;
  } bundle_t;

  typedef struct {
    bundle_t     b;
    logic        pre_clear;
    logic [31:0] exp_w;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: 0 loading, 1 full, 2 halted.
  int          m_state = 0;
  int          m_count = 0;
  logic        m_err   = 1'b0;
  logic        m_we    = 1'b0;
  logic        m_done  = 1'b0;
  logic [31:0] m_addr  = Base;
  logic [31:0] m_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bundle_t mk(input int fmt, input int op, input int rd, input int rs1,
                                 input int rs2, input int f3, input int f7,
                                 input logic [31:0] imm, input bit last);
    bundle_t b;
    b.fmt = 3'(fmt); b.op = 7'(op); b.rd = 5'(rd); b.rs1 = 5'(rs1); b.rs2 = 5'(rs2);
    b.f3 = 3'(f3); b.f7 = 1'(f7); b.imm = imm; b.last = last;
    return b;
  endfunction

  // Instruction word assembled from field values with shifts and masks.
  function automatic logic [31:0] ref_enc(input bundle_t b);
    int unsigned op, rd, rs1, rs2, f3, f7, im;
    op = b.op; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2; f3 = b.f3; f7 = b.f7; im = b.imm;
    case (b.fmt)
      3'd0: return (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      3'd1: begin
        if (op == 32'h13 && (f3 == 1 || f3 == 5))
          return (f7 << 30) | ((im & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        return ((im & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      3'd2: return (((im >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                   | ((im & 31) << 7) | op;
      3'd3: return (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (f3 << 12) | (((im >> 1) & 15) << 8)
                   | (((im >> 11) & 1) << 7) | op;
      3'd4: return (im & 32'hffff_f000) | (rd << 7) | op;
      3'd5: return (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3ff) << 21)
                   | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hff) << 12) | (rd << 7) | op;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_bad(input bundle_t b);
    return (b.fmt > 3'd5) || ((b.fmt == 3'd3 || b.fmt == 3'd5) && b.imm[0]);
  endfunction

  // One clock: drive, check in_ready, advance model, check registered outputs.
  task automatic cycle(input bit rst, input bit clr, input bit v, input bundle_t b);
    bit exp_ready;
    bit acc;
    reset = rst; clear = clr;
    bus.in_valid = v; bus.in_last = b.last; bus.fmt = b.fmt; bus.opcode = b.op;
    bus.rd = b.rd; bus.rs1 = b.rs1; bus.rs2 = b.rs2; bus.funct3 = b.f3;
    bus.funct7b5 = b.f7; bus.imm = b.imm;
    #1;
    exp_ready = (m_state == 0) && !clr;
    if (!rst) chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    acc = v && exp_ready;
    m_we = 1'b0; m_done = 1'b0;
    if (rst) begin
      m_state = 0; m_count = 0; m_err = 1'b0; m_addr = Base; m_wdata = '0;
    end else if (clr) begin
      m_state = 0; m_count = 0; m_err = 1'b0; m_addr = Base;
    end else if (acc) begin
      if (ref_bad(b)) begin
        m_err = 1'b1; m_state = 2;
      end else begin
        m_we = 1'b1; m_addr = Base + 32'(m_count * 4); m_wdata = ref_enc(b);
        m_count++; m_done = b.last;
        if (b.last || m_count == Depth) m_state = 1;
      end
    end
    @(posedge clk); #1;
    chk("mem_we", 32'(bus.mem_we), 32'(m_we));
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("count", 32'(count), 32'(m_count));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
  endtask

  function automatic bundle_t rnd_bundle();
    bundle_t b;
    b.fmt = ($urandom_range(0, 15) < 14) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
    b.op = 7'($urandom); b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
    b.f3 = 3'($urandom); b.f7 = 1'($urandom); b.imm = $urandom;
    if ($urandom_range(0, 3) == 0) begin
      b.op = 7'h13;
      b.f3 = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b101;
    end
    if ($urandom_range(0, 9) < 8) b.imm[0] = 1'b0;
    b.last = ($urandom_range(0, 9) == 0);
    return b;
  endfunction

  vec_t    vecs[6];
  bundle_t idle;
  bundle_t addi;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 1'b0);
    addi = mk(1, 'h13, 1, 0, 0, 0, 0, 32'd5, 1'b0);
    vecs[0] = '{b: addi, pre_clear: 1'b0, exp_w: 32'h0050_0093};
    vecs[1] = '{b: mk(0, 'h33, 3, 1, 2, 0, 0, 32'h0, 1'b0), pre_clear: 1'b1,
                exp_w: 32'h0020_81B3};
    vecs[2] = '{b: mk(0, 'h33, 3, 1, 2, 0, 1, 32'h0, 1'b0), pre_clear: 1'b0,
                exp_w: 32'h4020_81B3};
    vecs[3] = '{b: mk(2, 'h23, 0, 1, 2, 2, 0, 32'd12, 1'b0), pre_clear: 1'b0,
                exp_w: 32'h0020_A623};
    vecs[4] = '{b: mk(3, 'h63, 0, 1, 2, 0, 0, 32'hFFFF_FFF8, 1'b0), pre_clear: 1'b0,
                exp_w: 32'hFE20_8CE3};
    vecs[5] = '{b: mk(5, 'h6F, 1, 0, 0, 0, 0, 32'd8, 1'b1), pre_clear: 1'b0,
                exp_w: 32'h0080_00EF};

    // Reset state.
    cycle(1'b1, 1'b0, 1'b0, idle);
    cycle(1'b1, 1'b0, 1'b0, idle);

    // Directed encodings; add and sub go back to back without a bubble.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].pre_clear || m_state != 0) cycle(1'b0, 1'b1, 1'b0, idle);
      cycle(1'b0, 1'b0, 1'b1, vecs[i].b);
      chk("table_wdata", bus.mem_wdata, vecs[i].exp_w);
      chk("table_we", 32'(bus.mem_we), 32'h1);
    end
    chk("jal_done", 32'(done), 32'h1);
    cycle(1'b0, 1'b0, 1'b1, addi);
    chk("full_after_last", 32'(bus.mem_we), 32'h0);

    // Fill to depth; the fifth bundle stalls until clear, then lands at BASE_ADDR.
    cycle(1'b0, 1'b1, 1'b0, idle);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, addi);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, addi);
    chk("depth_count", 32'(count), 32'(Depth));
    cycle(1'b0, 1'b1, 1'b1, addi);
    cycle(1'b0, 1'b0, 1'b1, addi);
    chk("restart_addr", bus.mem_addr, Base);
    chk("restart_count", 32'(count), 32'h1);

    // Illegal format, then odd branch offset while halted; clear recovers.
    cycle(1'b0, 1'b1, 1'b0, idle);
    cycle(1'b0, 1'b0, 1'b1, mk(6, 'h33, 1, 1, 1, 0, 0, 32'h0, 1'b1));
    chk("err_set", 32'(err), 32'h1);
    cycle(1'b0, 1'b0, 1'b1, mk(3, 'h63, 0, 1, 2, 0, 0, 32'd3, 1'b0));
    chk("halt_ready", 32'(bus.in_ready), 32'h0);
    cycle(1'b0, 1'b1, 1'b0, idle);
    chk("err_cleared", 32'(err), 32'h0);
    cycle(1'b0, 1'b0, 1'b1, addi);
    chk("post_err_addr", bus.mem_addr, Base);
    // Odd offset on a jump is also rejected.
    cycle(1'b0, 1'b0, 1'b1, mk(5, 'h6F, 1, 0, 0, 0, 0, 32'd9, 1'b0));

    // Reset after an accept and reset alongside a valid bundle.
    cycle(1'b0, 1'b1, 1'b0, idle);
    cycle(1'b0, 1'b0, 1'b1, addi);
    cycle(1'b1, 1'b0, 1'b1, addi);
    chk("reset_we", 32'(bus.mem_we), 32'h0);
    chk("reset_wdata", bus.mem_wdata, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, idle);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit rst, clr, v;
      rst = ($urandom_range(0, 99) == 0);
      clr = (m_state != 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 29) == 0);
      v   = ($urandom_range(0, 9) < 7);
      cycle(rst, clr, v, rnd_bundle());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
